// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for a 5-stage MIPS32 pipeline: memory wait/timeout,
// taken branches, load-use and HI/LO-versus-mul/div hazards, plus a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES   = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_md_use,
  input  logic             ex_load,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_bubble,
  output logic             md_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MDW = $clog2(MD_CYCLES);
  localparam int TOW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_CYCLES - 1);
  localparam logic [TOW-1:0] TO_MAX  = TOW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_MEMW = 1'b1
  } mem_state_e;

  mem_state_e       state_q, state_d;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic [MDW-1:0]   md_cnt_q, md_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic freeze_s;
  logic load_use_s;
  logic md_busy_s;
  logic md_haz_s;

  logic pc_en_s;
  logic if_id_en_s;
  logic if_id_flush_s;
  logic id_ex_en_s;
  logic id_ex_flush_s;
  logic ex_mem_en_s;
  logic mem_wb_bubble_s;

  // The cycle after a timeout abort treats the access as complete, so freeze is masked.
  assign freeze_s   = mem_req & ~mem_ack & ~mem_err_q;
  assign load_use_s = ex_load & (ex_waddr != 5'd0) &
                      ((id_rs_used & (id_rs == ex_waddr)) |
                       (id_rt_used & (id_rt == ex_waddr)));
  assign md_busy_s  = (md_cnt_q != {MDW{1'b0}});
  assign md_haz_s   = md_busy_s & id_md_use;

  // Memory wait FSM next state with timeout counter and abort pulse.
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    mem_err_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (freeze_s) begin
          state_d  = ST_MEMW;
          to_cnt_d = TOW'(1'b1);
        end else begin
          state_d  = ST_RUN;
          to_cnt_d = {TOW{1'b0}};
        end
      end
      ST_MEMW: begin
        if (!freeze_s) begin
          state_d  = ST_RUN;
          to_cnt_d = {TOW{1'b0}};
        end else if (to_cnt_q == TO_MAX) begin
          state_d   = ST_RUN;
          to_cnt_d  = {TOW{1'b0}};
          mem_err_d = 1'b1;
        end else begin
          state_d  = ST_MEMW;
          to_cnt_d = to_cnt_q + TOW'(1'b1);
        end
      end
      default: begin
        state_d  = ST_RUN;
        to_cnt_d = {TOW{1'b0}};
      end
    endcase
  end

  // Mul/div countdown: the unit keeps running while the pipeline is frozen.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (ex_md_start && !freeze_s) begin
      md_cnt_d = MD_LOAD;
    end else if (md_busy_s) begin
      md_cnt_d = md_cnt_q - MDW'(1'b1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // Pipeline control resolution, priority freeze > branch > load-use > md-use.
  always_comb begin
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_en_s      = 1'b1;
    id_ex_flush_s   = 1'b0;
    ex_mem_en_s     = 1'b1;
    mem_wb_bubble_s = 1'b0;
    if (!rst) begin
      pc_en_s = 1'b1;
    end else if (freeze_s) begin
      pc_en_s         = 1'b0;
      if_id_en_s      = 1'b0;
      id_ex_en_s      = 1'b0;
      ex_mem_en_s     = 1'b0;
      mem_wb_bubble_s = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
    end else if (load_use_s || md_haz_s) begin
      pc_en_s       = 1'b0;
      if_id_en_s    = 1'b0;
      id_ex_flush_s = 1'b1;
    end else begin
      pc_en_s = 1'b1;
    end
  end

  // Stall counter wraps naturally at 2^CNT_W.
  always_comb begin
    if (!pc_en_s) begin
      stall_d = stall_q + CNT_W'(1'b1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers; reset abandons any pending access or mul/div operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      to_cnt_q  <= {TOW{1'b0}};
      md_cnt_q  <= {MDW{1'b0}};
      mem_err_q <= 1'b0;
      stall_q   <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      md_cnt_q  <= md_cnt_d;
      mem_err_q <= mem_err_d;
      stall_q   <= stall_d;
    end
  end

  assign pc_en         = pc_en_s;
  assign if_id_en      = if_id_en_s;
  assign if_id_flush   = if_id_flush_s;
  assign id_ex_en      = id_ex_en_s;
  assign id_ex_flush   = id_ex_flush_s;
  assign ex_mem_en     = ex_mem_en_s;
  assign mem_wb_bubble = mem_wb_bubble_s;
  assign md_busy       = rst & md_busy_s;
  assign mem_err       = mem_err_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus queues expected controls per cycle,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int MDC = 4;
  localparam int MTO = 4;
  localparam int CW  = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, md_busy, mem_err}
  localparam logic [8:0] NOH  = 9'b110101000;
  localparam logic [8:0] LU   = 9'b000111000;
  localparam logic [8:0] MDH  = 9'b000111010;
  localparam logic [8:0] FRZ  = 9'b000000100;
  localparam logic [8:0] FRZM = 9'b000000110;
  localparam logic [8:0] BR   = 9'b111111000;
  localparam logic [8:0] BRM  = 9'b111111010;
  localparam logic [8:0] BSY  = 9'b110101010;
  localparam logic [8:0] ERR  = 9'b110101001;

  logic clk, rst;
  logic [4:0] id_rs, id_rt, ex_waddr;
  logic id_rs_used, id_rt_used, id_md_use, ex_load, ex_md_start, ex_branch_taken;
  logic mem_req, mem_ack;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic mem_wb_bubble, md_busy, mem_err;
  logic [CW-1:0] stall_cycles;

  typedef struct {
    string         nm;
    logic [8:0]    e;
    logic [CW-1:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_it;
  int n_tests = 0;
  int n_fail  = 0;
  logic [CW-1:0] exp_stall;
  logic [8:0] act;

  pipe_hazard_ctrl #(.MD_CYCLES(MDC), .MEM_TIMEOUT(MTO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_md_use(id_md_use), .ex_load(ex_load), .ex_waddr(ex_waddr),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .md_busy(md_busy), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_bubble, md_busy, mem_err};

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_it = sb.pop_front();
      n_tests++;
      if (act !== mon_it.e || stall_cycles !== mon_it.s) begin
        n_fail++;
        $display("FAIL %s: got ctrl=%b stall=%0d, expected ctrl=%b stall=%0d",
                 mon_it.nm, act, stall_cycles, mon_it.e, mon_it.s);
      end
    end
  end

  task automatic cyc(input string nm, input logic [8:0] e);
    exp_t it;
    if (!rst) exp_stall = '0;
    it.nm = nm;
    it.e  = e;
    it.s  = exp_stall;
    sb.push_back(it);
    if (rst && !e[8]) exp_stall = exp_stall + CW'(1);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = 5'd0; id_rt = 5'd0; ex_waddr = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_md_use = 1'b0;
    ex_load = 1'b0; ex_md_start = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    exp_stall = '0;
    clr();
    // hazards presented during reset must be ignored
    ex_load = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1; mem_req = 1'b1;
    @(posedge clk); #1;
    cyc("reset_forced", NOH);
    clr();
    rst = 1'b1;
    cyc("idle", NOH);

    ex_load = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
    cyc("loaduse_rs", LU);
    clr();
    cyc("loaduse_done", NOH);
    ex_load = 1'b1; ex_waddr = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
    cyc("loaduse_r0", NOH);
    clr();
    ex_load = 1'b1; ex_waddr = 5'd7; id_rt = 5'd7; id_rt_used = 1'b1;
    cyc("loaduse_rt", LU);
    id_rt_used = 1'b0;
    cyc("rt_unused", NOH);
    clr();

    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("memwait", FRZ);
    mem_ack = 1'b1;
    cyc("mem_ack", NOH);
    cyc("mem_zero_wait", NOH);
    clr();

    mem_req = 1'b1;
    for (int i = 0; i < MTO + 1; i++) cyc("timeout_wait", FRZ);
    cyc("timeout_err", ERR);
    mem_req = 1'b0;
    cyc("after_timeout", NOH);

    ex_md_start = 1'b1;
    cyc("md_start", NOH);
    ex_md_start = 1'b0; id_md_use = 1'b1;
    for (int i = 0; i < MDC - 1; i++) cyc("md_use_stall", MDH);
    cyc("md_done", NOH);
    id_md_use = 1'b0;
    ex_md_start = 1'b1;
    cyc("md_start2", NOH);
    ex_md_start = 1'b0;
    for (int i = 0; i < MDC - 1; i++) cyc("md_indep", BSY);
    cyc("md_idle", NOH);

    mem_req = 1'b1; ex_md_start = 1'b1;
    cyc("md_start_frozen", FRZ);
    mem_ack = 1'b1; ex_md_start = 1'b0;
    cyc("md_not_started", NOH);
    clr();

    ex_md_start = 1'b1;
    cyc("md_start3", NOH);
    ex_md_start = 1'b0; mem_req = 1'b1; id_md_use = 1'b1;
    cyc("md_frozen_a", FRZM);
    cyc("md_frozen_b", FRZM);
    mem_ack = 1'b1;
    cyc("md_after_freeze", MDH);
    mem_req = 1'b0; mem_ack = 1'b0;
    cyc("md_expired", NOH);
    clr();

    ex_branch_taken = 1'b1;
    ex_load = 1'b1; ex_waddr = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
    cyc("branch_over_lu", BR);
    mem_req = 1'b1;
    cyc("freeze_over_br", FRZ);
    mem_ack = 1'b1;
    cyc("branch_on_ack", BR);
    clr();
    ex_md_start = 1'b1;
    cyc("md_start4", NOH);
    ex_md_start = 1'b0; id_md_use = 1'b1; ex_branch_taken = 1'b1;
    cyc("branch_over_md", BRM);
    ex_branch_taken = 1'b0;
    cyc("md_use_b", MDH);
    cyc("md_use_c", MDH);
    cyc("md_clear", NOH);
    clr();

    ex_md_start = 1'b1;
    cyc("md_reload_a", NOH);
    cyc("md_reload_b", BSY);
    ex_md_start = 1'b0;
    for (int i = 0; i < MDC - 1; i++) cyc("md_reloaded", BSY);
    cyc("md_reload_end", NOH);

    ex_md_start = 1'b1;
    cyc("md_start5", NOH);
    ex_md_start = 1'b0; mem_req = 1'b1;
    cyc("pre_reset_frz", FRZM);
    rst = 1'b0;
    cyc("async_reset", NOH);
    clr();
    rst = 1'b1; id_md_use = 1'b1;
    cyc("post_reset", NOH);
    clr();
    cyc("final_idle", NOH);

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
